v_dividers_seq: RTL and testbench

Sequential unsigned radix-2 restoring divider: the inverse datapath to the team's pipelined 18x18 multiplier, sized so a 36-bit product divided by an 18-bit factor recovers the other factor. Operands enter through a valid/ready handshake. The block iterates one quotient bit per clock. It holds quotient, remainder and a divide-by-zero flag until the consumer accepts them. It targets LUT/FF fabric with no DSP use, for dividing accumulated products back down in fixed-point datapaths.

---
 rtl/v_dividers_seq_pkg.sv | 14 +
 rtl/v_dividers_seq_if.sv | 30 +++
 rtl/v_dividers_seq_step.sv | 23 ++
 rtl/v_dividers_seq.sv | 80 ++++++++
 tb/tb_v_dividers_seq.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/v_dividers_seq_pkg.sv
// Shared definitions for the sequential restoring divider: FSM encoding and
// default operand widths matching the 18x18 multiplier it inverts.
package v_dividers_pkg;

   localparam int unsigned WN_DEFAULT = 36;
   localparam int unsigned WD_DEFAULT = 18;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/v_dividers_seq_if.sv
// Operand/result handshake bundle for v_dividers_seq; master is the
// producer/consumer side, slave is the divider.
interface v_dividers_seq_if
   import v_dividers_pkg::*;
#(
   parameter int unsigned WN = WN_DEFAULT,
   parameter int unsigned WD = WD_DEFAULT
);

   logic          in_valid;
   logic          in_ready;
   logic [WN-1:0] dividend;
   logic [WD-1:0] divisor;
   logic          out_valid;
   logic          out_ready;
   logic [WN-1:0] quotient;
   logic [WD-1:0] remainder;
   logic          div_by_zero;

   modport master (
      output in_valid, dividend, divisor, out_ready,
      input  in_ready, out_valid, quotient, remainder, div_by_zero
   );

   modport slave (
      input  in_valid, dividend, divisor, out_ready,
      output in_ready, out_valid, quotient, remainder, div_by_zero
   );

endinterface

// File: rtl/v_dividers_seq_step.sv
// One combinational restoring-division step: shift the next dividend bit into
// the partial remainder and subtract the divisor when it fits.
module v_div_step #(
   parameter int unsigned WD = 18
) (
   input  logic [WD:0]   r,
   input  logic          shift_bit,
   input  logic [WD-1:0] d,
   output logic [WD:0]   r_next,
   output logic          q_bit
);

   logic [WD+1:0] shifted;

   // The partial remainder stays below d, so the compare-and-subtract is the
   // same as testing the sign of {r[WD-1:0], bit} - d.
   always_comb begin
      shifted = {r, shift_bit};
      q_bit   = (shifted >= {2'b00, d});
      r_next  = q_bit ? (WD+1)'(shifted - {2'b00, d}) : shifted[WD:0];
   end

endmodule

// File: rtl/v_dividers_seq.sv
// Sequential unsigned radix-2 restoring divider, one quotient bit per clock,
// with valid/ready handshakes on operands and results.
module v_dividers_seq
   import v_dividers_pkg::*;
#(
   parameter int unsigned WN = WN_DEFAULT,
   parameter int unsigned WD = WD_DEFAULT
) (
   input logic             clk,
   input logic             rst_n,
   v_dividers_seq_if.slave bus
);

   localparam int unsigned CW = (WN > 1) ? $clog2(WN) : 1;

   state_t        state_q;
   state_t        state_d;
   logic [WN-1:0] q;
   logic [WD:0]   r;
   logic [WD:0]   r_next;
   logic [WD-1:0] d;
   logic [CW-1:0] count;
   logic          dbz;
   logic          q_bit;
   logic          accept;

   assign accept = bus.in_valid && (state_q == IDLE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (bus.in_valid)    state_d = CALC;
         CALC:    if (count == '0)     state_d = DONE;
         DONE:    if (bus.out_ready)   state_d = IDLE;
         default:                      state_d = IDLE;
      endcase
   end

   v_div_step #(.WD(WD)) step (
      .r         (r),
      .shift_bit (q[WN-1]),
      .d         (d),
      .r_next    (r_next),
      .q_bit     (q_bit)
   );

   // With d == 0 every step "fits", so q fills with ones and r ends up holding
   // the low dividend bits: the divide-by-zero result needs no extra muxing.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q     <= '0;
         r     <= '0;
         d     <= '0;
         count <= '0;
         dbz   <= 1'b0;
      end else if (accept) begin
         q     <= bus.dividend;
         d     <= bus.divisor;
         r     <= '0;
         count <= CW'(WN - 1);
         dbz   <= (bus.divisor == '0);
      end else if (state_q == CALC) begin
         q <= {q[WN-2:0], q_bit};
         r <= r_next;
         if (count != '0) count <= count - CW'(1);
      end
   end

   assign bus.in_ready    = (state_q == IDLE);
   assign bus.out_valid   = (state_q == DONE);
   assign bus.quotient    = q;
   assign bus.remainder   = r[WD-1:0];
   assign bus.div_by_zero = dbz;

endmodule

// File: tb/tb_v_dividers_seq.sv
// Directed and randomized checks of v_dividers_seq against an arithmetic
// reference (N / D, N % D) with latency and handshake timing checks.
module tb_v_dividers_seq;

   localparam int unsigned WN = 36;
   localparam int unsigned WD = 18;

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;
   int   last_acc = -1;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   v_dividers_seq_if #(.WN(WN), .WD(WD)) bus ();

   v_dividers_seq #(.WN(WN), .WD(WD)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_out(output int lat);
      lat = 0;
      while (bus.out_valid !== 1'b1 && lat < 100) begin
         tick();
         lat++;
      end
   endtask

   task automatic do_op(input string tag, input logic [WN-1:0] n, input logic [WD-1:0] dv,
                        input int gap, input int hold, input logic cur_ready,
                        input logic [WN-1:0] eq, input logic [WD-1:0] er, input logic ez);
      int w;
      int lat;
      logic [63:0] junk;
      repeat (gap) tick();
      bus.dividend = n;
      bus.divisor  = dv;
      bus.in_valid = 1'b1;
      w = 0;
      while (bus.in_ready !== 1'b1 && w < 200) begin
         tick();
         w++;
      end
      check({tag, "_ready"}, bus.in_ready, 1);
      tick();
      bus.in_valid = 1'b0;
      junk = {$urandom, $urandom};
      bus.dividend = junk[WN-1:0];
      bus.divisor  = junk[WD-1:0];
      bus.out_ready = cur_ready;
      if (last_acc >= 0) check({tag, "_spacing_ok"}, (cyc - last_acc) >= int'(WN + 2), 1);
      last_acc = cyc;
      wait_out(lat);
      check({tag, "_latency"}, lat, WN);
      check({tag, "_quotient"}, bus.quotient, eq);
      check({tag, "_remainder"}, bus.remainder, er);
      check({tag, "_dbz"}, bus.div_by_zero, ez);
      bus.out_ready = 1'b0;
      repeat (hold) begin
         tick();
         check({tag, "_hold_valid"}, bus.out_valid, 1);
         check({tag, "_hold_q"}, bus.quotient, eq);
      end
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
      check({tag, "_idle_ready"}, bus.in_ready, 1);
      check({tag, "_idle_valid"}, bus.out_valid, 0);
   endtask

   initial begin
      int lat;
      int seen;
      logic [63:0]   rnd;
      logic [WN-1:0] n;
      logic [WD-1:0] dv;
      logic [WN-1:0] eq;
      logic [WD-1:0] er;
      logic          ez;
      int            sel;

      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      bus.dividend  = '0;
      bus.divisor   = '0;

      #2 rst_n = 1'b0;
      #1;
      check("rst_in_ready", bus.in_ready, 1);
      check("rst_out_valid", bus.out_valid, 0);
      check("rst_quotient", bus.quotient, 0);
      check("rst_remainder", bus.remainder, 0);
      check("rst_dbz", bus.div_by_zero, 0);
      tick();
      tick();
      rst_n = 1'b1;
      tick();

      do_op("n1000_d7", 36'd1000, 18'd7, 0, 0, 1'b0, 36'd142, 18'd6, 1'b0);
      do_op("max_d1", 36'hFFFFFFFFF, 18'd1, 0, 0, 1'b1, 36'hFFFFFFFFF, 18'd0, 1'b0);
      do_op("n5_d9", 36'd5, 18'd9, 0, 0, 1'b0, 36'd0, 18'd5, 1'b0);
      do_op("square", 36'hFFFF80001, 18'h3FFFF, 0, 0, 1'b1, 36'h3FFFF, 18'd0, 1'b0);
      do_op("div0", 36'd100, 18'd0, 0, 0, 1'b0, 36'hFFFFFFFFF, 18'd100, 1'b1);
      do_op("after_div0", 36'd9, 18'd3, 0, 0, 1'b0, 36'd3, 18'd0, 1'b0);

      // Back-pressure with a new request waiting behind the held result
      last_acc = -1;
      bus.dividend = 36'd1000;
      bus.divisor  = 18'd7;
      bus.in_valid = 1'b1;
      tick();
      bus.in_valid = 1'b0;
      wait_out(lat);
      check("bp_latency", lat, WN);
      bus.dividend = 36'd9;
      bus.divisor  = 18'd3;
      bus.in_valid = 1'b1;
      repeat (10) begin
         tick();
         check("bp_valid", bus.out_valid, 1);
         check("bp_in_ready", bus.in_ready, 0);
         check("bp_quotient", bus.quotient, 142);
         check("bp_remainder", bus.remainder, 6);
      end
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
      check("bp_hs_ready", bus.in_ready, 1);
      check("bp_hs_valid", bus.out_valid, 0);
      tick();
      check("bp_accepted", bus.in_ready, 0);
      bus.in_valid = 1'b0;
      wait_out(lat);
      check("bp2_latency", lat, WN);
      check("bp2_quotient", bus.quotient, 3);
      check("bp2_remainder", bus.remainder, 0);
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;

      // Reset in the middle of an iteration sequence
      bus.dividend = 36'd1000;
      bus.divisor  = 18'd7;
      bus.in_valid = 1'b1;
      tick();
      bus.in_valid = 1'b0;
      repeat (20) tick();
      #2 rst_n = 1'b0;
      #1;
      check("mid_rst_in_ready", bus.in_ready, 1);
      check("mid_rst_out_valid", bus.out_valid, 0);
      check("mid_rst_quotient", bus.quotient, 0);
      check("mid_rst_remainder", bus.remainder, 0);
      check("mid_rst_dbz", bus.div_by_zero, 0);
      tick();
      rst_n = 1'b1;
      seen = 0;
      repeat (50) begin
         tick();
         if (bus.out_valid === 1'b1) seen++;
      end
      check("mid_rst_no_result", seen, 0);
      do_op("n77_d11", 36'd77, 18'd11, 0, 0, 1'b0, 36'd7, 18'd0, 1'b0);

      // Randomized traffic against the arithmetic model
      last_acc = -1;
      for (int i = 0; i < 1000; i++) begin
         rnd = {$urandom, $urandom};
         n   = rnd[WN-1:0];
         sel = $urandom_range(0, 7);
         rnd = 64'($urandom);
         dv  = rnd[WD-1:0];
         if (sel == 0) dv = '0;
         if (sel == 1) dv = WD'($urandom_range(1, 15));
         if (sel == 2) n  = WN'($urandom_range(0, 1000));
         if (dv == '0) begin
            eq = '1;
            er = n[WD-1:0];
            ez = 1'b1;
         end else begin
            eq = n / dv;
            er = WD'(n % dv);
            ez = 1'b0;
         end
         do_op("rand", n, dv,
               ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0,
               ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0,
               1'($urandom_range(0, 1)), eq, er, ez);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
